// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Bridges the M stage of the pipeline to a variable-latency data memory
//   that uses a req/ready handshake. For each load or store, the block
//   issues one request and freezes the pipeline until the memory answers.
//   It also builds byte enables, replicates store data across byte lanes,
//   and aligns and extends load data. Misaligned accesses and bus timeouts
//   are flagged.
//
// Ports:
//   clk, rst_n    pipeline clock, asynchronous active-low reset
//   MemWriteM     store in M stage
//   MemReadM      load in M stage
//   funct3M       access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   ALUResultM    byte address of the access
//   WriteDataM    store data, LSB-aligned
//   mem_req       request valid to the data memory
//   mem_we        1 = write
//   mem_addr      word-aligned address
//   mem_wdata     lane-replicated store data
//   mem_be        byte enables
//   mem_ready     memory completes the request this cycle
//   mem_rdata     read word, valid together with mem_ready
//   StallM        freezes the F/D/E/M pipeline registers
//   ReadDataM     aligned, extended load result (registered)
//   MisalignM     misaligned-access flag (combinational)
//   BusErrM       one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int word_width = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [2:0]            funct3M,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [word_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [word_width-1:0] mem_rdata,
  output logic                  StallM,
  output logic [word_width-1:0] ReadDataM,
  output logic                  MisalignM,
  output logic                  BusErrM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  memReq_q;
  logic                  memWe_q;
  logic [word_width-1:0] memAddr_q;
  logic [word_width-1:0] memWdata_q;
  logic [3:0]            memBe_q;
  logic                  isLoad_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [word_width-1:0] readData_q;
  logic                  busErr_q;

  logic                  access;
  logic                  isByte;
  logic                  isHalf;
  logic                  misaligned;
  logic [1:0]            off;
  logic [3:0]            memBe_d;
  logic [word_width-1:0] memWdata_d;
  logic [word_width-1:0] shifted;
  logic [word_width-1:0] loadData_d;

  // Decode of the incoming access. A set MemWriteM wins over MemReadM.
  // funct3 encodings outside byte/half are all handled as a full word.
  assign access     = MemWriteM | MemReadM;
  assign off        = ALUResultM[1:0];
  assign isByte     = (funct3M[1:0] == 2'b00);
  assign isHalf     = (funct3M[1:0] == 2'b01);
  assign misaligned = (isHalf & off[0]) | (~isByte & ~isHalf & (off != 2'b00));

  // Byte enables and lane-replicated store data for the request about to
  // be issued. Replication lets the memory take data from whichever lanes
  // are enabled without shifting anything itself.
  always_comb begin
    memBe_d    = 4'hF;
    memWdata_d = WriteDataM;
    if (isByte) begin
      memBe_d    = 4'b0001 << off;
      memWdata_d = {(word_width/8){WriteDataM[7:0]}};
    end else if (isHalf) begin
      memBe_d    = 4'b0011 << off;
      memWdata_d = {(word_width/16){WriteDataM[15:0]}};
    end
  end

  // Align the returned word so the addressed byte/half sits in the LSBs,
  // then sign- or zero-extend it according to the captured funct3.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  loadData_d = {{(word_width-8){shifted[7]}}, shifted[7:0]};
      3'b001:  loadData_d = {{(word_width-16){shifted[15]}}, shifted[15:0]};
      3'b100:  loadData_d = {{(word_width-8){1'b0}}, shifted[7:0]};
      3'b101:  loadData_d = {{(word_width-16){1'b0}}, shifted[15:0]};
      default: loadData_d = mem_rdata;
    endcase
  end

  // Access sequencer. Request fields are captured once in IDLE and held
  // through WAIT. DONE is a single cycle with the stall released, so the
  // pipeline advances exactly once and the same M-stage instruction is
  // never issued twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memBe_q    <= 4'h0;
      isLoad_q   <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      readData_q <= '0;
      busErr_q   <= 1'b0;
    end else begin
      busErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access && !misaligned) begin
            memReq_q   <= 1'b1;
            memWe_q    <= MemWriteM;
            memAddr_q  <= {ALUResultM[word_width-1:2], 2'b00};
            memWdata_q <= memWdata_d;
            memBe_q    <= memBe_d;
            isLoad_q   <= ~MemWriteM;
            funct3_q   <= funct3M;
            off_q      <= off;
            cnt_q      <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            if (isLoad_q) begin
              readData_q <= loadData_d;
            end
            state_q <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // The memory never answered: abandon the request and report it.
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            readData_q <= '0;
            busErr_q   <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The stall is raised in IDLE as soon as a legal access appears, so the
  // instruction is held in M before the request is even registered. It is
  // gated by rst_n so that asserting reset releases the pipeline at once.
  assign StallM    = rst_n & (((state_q == IDLE) & access & ~misaligned) |
                              (state_q == WAIT));
  assign MisalignM = (state_q == IDLE) & access & misaligned;

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_be    = memBe_q;
  assign ReadDataM = readData_q;
  assign BusErrM   = busErr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Purpose:
//   Directed self-checking bench for mem_access_ctrl. It covers stores and
//   loads of every size, misaligned rejection, the bus timeout, and reset
//   during an outstanding access. Expected values are computed by hand from
//   the access semantics.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        MemWriteM;
  logic        MemReadM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;
  logic        BusErrM;

  int assertCount;
  int failCount;

  int          stallSeen;
  int          reqSeen;
  logic [3:0]  beSeen;
  logic [31:0] wdataSeen;
  logic [31:0] addrSeen;
  logic        weSeen;

  mem_access_ctrl #(
    .word_width(32),
    .TIMEOUT   (16),
    .CNT_W     (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemWriteM (MemWriteM),
    .MemReadM  (MemReadM),
    .funct3M   (funct3M),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .StallM    (StallM),
    .ReadDataM (ReadDataM),
    .MisalignM (MisalignM),
    .BusErrM   (BusErrM)
  );

  // 10 ns clock; the DUT acts on posedge, and the bench drives and samples
  // around negedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the M-stage inputs of the instruction under test.
  task automatic applyStimulus(input logic we, input logic rd, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM  = we;
    MemReadM   = rd;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wdata;
  endtask

  // One comparison: count it, and report it on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Run one access from the negedge at which it is presented until DONE.
  // The memory answers on the readyAt-th request cycle; 0 means never.
  // The loop is bounded, so a stuck stall shows up as a wrong stall count.
  // On return the bench sits just after the DONE negedge.
  task automatic runAccess(input logic we, input logic rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int readyAt, input logic [31:0] rdata);
    stallSeen = 0;
    reqSeen   = 0;
    beSeen    = 4'h0;
    wdataSeen = 32'h0;
    addrSeen  = 32'h0;
    weSeen    = 1'b0;
    @(negedge clk);
    applyStimulus(we, rd, f3, addr, wdata);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!StallM) break;
      stallSeen++;
      if (mem_req) begin
        reqSeen++;
        if (reqSeen == 1) begin
          beSeen    = mem_be;
          wdataSeen = mem_wdata;
          addrSeen  = mem_addr;
          weSeen    = mem_we;
        end
        if (reqSeen == readyAt) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  // Leave DONE with the instruction retired and step to a quiet IDLE.
  task automatic retire();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    mem_ready   = 1'b0;
    mem_rdata   = 32'h0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset mem_req",   32'(mem_req),   32'h0);
    checkOutput("reset mem_we",    32'(mem_we),    32'h0);
    checkOutput("reset ReadDataM", ReadDataM,      32'h0);
    checkOutput("reset BusErrM",   32'(BusErrM),   32'h0);
    checkOutput("reset StallM",    32'(StallM),    32'h0);
    rst_n = 1'b1;

    // SW 0x100 <- 0xDEADBEEF, ready on the first WAIT cycle
    runAccess(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    checkOutput("SW stall cycles", 32'(stallSeen), 32'd2);
    checkOutput("SW req cycles",   32'(reqSeen),   32'd1);
    checkOutput("SW be",           32'(beSeen),    32'hF);
    checkOutput("SW we",           32'(weSeen),    32'h1);
    checkOutput("SW addr",         addrSeen,       32'h100);
    checkOutput("SW wdata",        wdataSeen,      32'hDEADBEEF);
    checkOutput("SW done req",     32'(mem_req),   32'h0);
    checkOutput("SW ReadDataM",    ReadDataM,      32'h0);
    retire();
    checkOutput("SW idle stall",   32'(StallM),    32'h0);

    // LB 0x203, data 0x80112233, ready on the third WAIT cycle
    runAccess(1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 3, 32'h80112233);
    checkOutput("LB stall cycles", 32'(stallSeen), 32'd4);
    checkOutput("LB be",           32'(beSeen),    32'h8);
    checkOutput("LB we",           32'(weSeen),    32'h0);
    checkOutput("LB addr",         addrSeen,       32'h200);
    checkOutput("LB ReadDataM",    ReadDataM,      32'hFFFFFF80);
    retire();

    // LBU, same access
    runAccess(1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 3, 32'h80112233);
    checkOutput("LBU stall cycles", 32'(stallSeen), 32'd4);
    checkOutput("LBU ReadDataM",    ReadDataM,      32'h00000080);
    retire();

    // SH 0x402 <- 0xABCD; the load result must be left untouched
    runAccess(1'b1, 1'b0, 3'b001, 32'h402, 32'h0000ABCD, 1, 32'h0);
    checkOutput("SH be",           32'(beSeen),    32'hC);
    checkOutput("SH wdata",        wdataSeen,      32'hABCDABCD);
    checkOutput("SH addr",         addrSeen,       32'h400);
    checkOutput("SH ReadDataM",    ReadDataM,      32'h00000080);
    retire();

    // SB 0x101 <- 0x5A
    runAccess(1'b1, 1'b0, 3'b000, 32'h101, 32'h1234565A, 2, 32'h0);
    checkOutput("SB be",           32'(beSeen),    32'h2);
    checkOutput("SB wdata",        wdataSeen,      32'h5A5A5A5A);
    checkOutput("SB stall cycles", 32'(stallSeen), 32'd3);
    retire();

    // LH / LHU upper half, LW full word
    runAccess(1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 1, 32'h80112233);
    checkOutput("LH be",           32'(beSeen),    32'hC);
    checkOutput("LH ReadDataM",    ReadDataM,      32'hFFFF8011);
    retire();
    runAccess(1'b0, 1'b1, 3'b101, 32'h202, 32'h0, 1, 32'h80112233);
    checkOutput("LHU ReadDataM",   ReadDataM,      32'h00008011);
    retire();
    runAccess(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 1, 32'h12345678);
    checkOutput("LW ReadDataM",    ReadDataM,      32'h12345678);
    retire();

    // Misaligned LW 0x105: flagged, no request, no stall
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h105, 32'h0);
    #1;
    checkOutput("MIS MisalignM",   32'(MisalignM), 32'h1);
    checkOutput("MIS StallM",      32'(StallM),    32'h0);
    @(negedge clk);
    #1;
    checkOutput("MIS mem_req",     32'(mem_req),   32'h0);
    checkOutput("MIS still flag",  32'(MisalignM), 32'h1);
    retire();
    checkOutput("MIS cleared",     32'(MisalignM), 32'h0);

    // Timeout: the memory never answers
    runAccess(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 0, 32'h0);
    checkOutput("TO stall cycles", 32'(stallSeen), 32'd17);
    checkOutput("TO req cycles",   32'(reqSeen),   32'd16);
    checkOutput("TO BusErrM",      32'(BusErrM),   32'h1);
    checkOutput("TO ReadDataM",    ReadDataM,      32'h0);
    checkOutput("TO mem_req",      32'(mem_req),   32'h0);
    retire();
    checkOutput("TO pulse end",    32'(BusErrM),   32'h0);
    checkOutput("TO idle stall",   32'(StallM),    32'h0);

    // Reset in the middle of WAIT
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("RST pre req",     32'(mem_req),   32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("RST mem_req",     32'(mem_req),   32'h0);
    checkOutput("RST StallM",      32'(StallM),    32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (BusErrM || mem_req || StallM) break;
    end
    checkOutput("RST no BusErrM",  32'(BusErrM),   32'h0);
    checkOutput("RST idle req",    32'(mem_req),   32'h0);

    // After reset the controller is in IDLE and takes a fresh access
    runAccess(1'b1, 1'b0, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'h0);
    checkOutput("POST stall",      32'(stallSeen), 32'd2);
    checkOutput("POST addr",       addrSeen,       32'h104);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences load/store accesses from the pipeline memory stage (M) onto a variable-latency data-memory port using a req/ready handshake. Stalls the pipeline while an access is outstanding. Generates byte enables, aligns and extends load data, and flags misaligned accesses and bus timeouts. Sits between the E/M pipeline register outputs (RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM) and the data memory.

Parameters:
word_width, 32, data/address width
TIMEOUT, 16, maximum WAIT cycles before a bus error; must be >= 1
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store in M stage
MemReadM  in  1  load in M stage (ResultSrcM==2'b01)
funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ALUResultM  in  word_width  byte address
WriteDataM  in  word_width  store data, LSB-aligned
mem_req  out  1  request valid to data memory
mem_we  out  1  1 = write
mem_addr  out  word_width  word address {ALUResultM[31:2],2'b00}
mem_wdata  out  word_width  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  memory completes the request this cycle
mem_rdata  in  word_width  read word, valid when mem_ready
StallM  out  1  freeze F/D/E/M pipeline registers
ReadDataM  out  word_width  aligned, extended load result (registered)
MisalignM  out  1  misaligned-access flag (combinational)
BusErrM  out  1  timeout flag, one-cycle pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req=0, mem_we=0, ReadDataM=0, BusErrM=0, counter=0. Reset during WAIT drops mem_req immediately; no completion is reported.
- access = MemWriteM | MemReadM. misaligned = (size half & addr[0]) | (size word & addr[1:0]!=0). If both MemWriteM and MemReadM are set, the access is a store.
- States: IDLE, WAIT, DONE.
- IDLE: access & ~misaligned -> StallM=1 combinationally; register mem_req=1, mem_we, mem_addr, mem_wdata, mem_be; go WAIT. access & misaligned -> MisalignM=1, StallM=0, no request, stay IDLE. No access -> StallM=0.
- WAIT: StallM=1; mem_req and all request fields held stable until accepted. On mem_ready: drop mem_req; for loads, register ReadDataM from mem_rdata; go DONE. Otherwise increment counter; when counter==TIMEOUT-1 without mem_ready: drop mem_req, ReadDataM=0, BusErrM=1 for one cycle, go DONE.
- DONE: StallM=0 so the pipeline advances exactly once; counter cleared; go IDLE unconditionally. DONE never starts a new request, which prevents re-issuing the same M-stage instruction. ReadDataM holds until the next load completes.
- Minimum cost is 2 stall cycles (IDLE detect, WAIT with immediate ready); the access then completes in DONE.
- mem_be and mem_wdata by size, with off = addr[1:0]:
  - byte: be = 4'b0001<<off; wdata = {4{WriteDataM[7:0]}}.
  - half: be = 4'b0011<<off; wdata = {2{WriteDataM[15:0]}}.
  - word: be = 4'hF; wdata = WriteDataM.
  - Loads drive be per size; mem_we=0.
- Load extract: byte = mem_rdata[8*off +: 8]; half = mem_rdata[8*off +: 16]. Sign-extend for funct3 000/001; zero-extend for 100/101; word passes through.
- Inputs are sampled only in IDLE. Changes to the inputs during WAIT are ignored.

Test Plan:
- Reset then SW addr 0x100, data 0xDEADBEEF, mem_ready on the first WAIT cycle -> mem_req 1 cycle, mem_be=4'hF, mem_we=1, StallM high 2 cycles, low in DONE.
- LB addr 0x203, mem_rdata=0x80112233, ready after 3 WAIT cycles -> StallM high 4 cycles, ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x402, WriteDataM=0x0000ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x400.
- LW addr 0x105 -> MisalignM=1, mem_req stays 0, StallM=0.
- Load with mem_ready never asserted, TIMEOUT=16 -> mem_req drops after 16 WAIT cycles, BusErrM pulses once, ReadDataM=0, StallM releases in DONE.
- rst_n low mid-WAIT -> mem_req=0 and StallM=0 immediately; after release, state is IDLE and there is no BusErrM.
